read_ecc_correct: RTL
=====================

Name: read_ecc_correct

Overview:
- Sits directly downstream of the page-read/ECC-compare stage.
- Collects the per-128B-chunk ECC verdicts (`ecc_state`, `change_addr`) that the stage emits during the compare phase (flash state 18).
- After the end-of-compare pulse, applies single-bit corrections to the 8 KB page buffer RAM by read-modify-write, then reports a page-level status.
- Its output is the handshake telling the host-side reader that the page buffer holds corrected data.

Parameters:
- MAX_FIX, 64, capacity of the correction list (one entry per chunk; 64 chunks per 8 KB page).
- PAGE_AW, 13, page buffer byte-address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- page_start  in  1  one-cycle pulse at start of each page read; clears list and status.
- ecc_state_in  in  2  per-chunk verdict: 0 none, 1 clean, 2 correctable, 3 uncorrectable; each non-zero value is held exactly one cycle.
- change_addr_in  in  16  [15:10] chunk, [9:3] byte within chunk, [2:0] bit index; meaningful when ecc_state_in==2.
- ecc_success_in  in  1  one-cycle pulse: all 64 chunk verdicts delivered.
- pram_en  out  1  page RAM enable.
- pram_we  out  1  page RAM write enable.
- pram_addr  out  PAGE_AW  page RAM byte address.
- pram_din  out  8  page RAM write data.
- pram_dout  in  8  page RAM read data; synchronous, 1-cycle latency.
- busy  out  1  high in FIX_RD/FIX_WAIT/FIX_WR.
- done  out  1  one-cycle pulse: page correction finished.
- page_status  out  2  0 clean, 1 corrected, 2 uncorrectable; valid from done until next page_start.
- fix_cnt  out  7  number of corrections recorded for the page (0..64).

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; list empty; uncorrectable flag and overflow flag 0.
- IDLE (collect):
  - ecc_state_in==2: append {chunk, byte, bit} (16 b) at index fix_cnt; fix_cnt+1.
  - ecc_state_in==3: set the uncorrectable flag.
  - ecc_state_in==1 or 0: no action.
  - Append when fix_cnt==MAX_FIX: entry dropped, overflow flag set.
- page_start in IDLE or DONE: fix_cnt, flags and page_status cleared next cycle. An ecc_state_in event in the same cycle is discarded.
- ecc_success_in sampled in IDLE (an event in the same cycle is included first):
  - Uncorrectable or overflow flag set: go to DONE, page_status=2, RAM untouched.
  - Else fix_cnt==0: go to DONE, page_status=0.
  - Else: idx=0, go to FIX_RD.
- FIX_RD: pram_en=1, pram_we=0, pram_addr={entry[15:10], entry[9:3]}. Next state FIX_WAIT.
- FIX_WAIT: pram_en=0; capture pram_dout. Next state FIX_WR.
- FIX_WR:
  - pram_en=1, pram_we=1, same address, pram_din = captured byte XOR (8'h01 << entry[2:0]).
  - If idx==fix_cnt-1: go to DONE with page_status=1; else idx+1 and go to FIX_RD.
- DONE: done=1 for exactly this one cycle, then IDLE. page_status and fix_cnt are held until page_start.
- Latency: done is high in the (3·N+1)th cycle after the cycle that sampled ecc_success_in, where N = fix_cnt (N=0 gives 1 cycle).
- Outside FIX_RD/FIX_WR: pram_en=0, pram_we=0, pram_addr=0, pram_din=0.
- While busy: ecc_state_in and ecc_success_in are ignored.
- page_start while busy: abort. Next cycle go to IDLE and clear list/flags; done not pulsed. Any write already issued stands.
- rst mid-fix: immediate return to reset values on the next edge; no further RAM writes.
- Address arithmetic: byte address = chunk·128 + byte (13 bits, no overflow possible). Bit index 0 = LSB.

Test Plan:
- Clean page: page_start; 64× ecc_state_in=1; ecc_success_in → done 1 cycle later, page_status=0, fix_cnt=0, no pram_we pulses.
- Single fix: RAM[0x0285]=0xA5; event state=2, change_addr={6'd5, 7'd5, 3'd3}; success → one read then one write at 0x0285 with din=0xAD; done at cycle 4; page_status=1.
- Three fixes in chunks 0, 31, 63 at bit 7/0/4 → writes at the three addresses, each with the correct XOR; done at cycle 10; fix_cnt=3.
- Mixed: one state=2 and one state=3 → done at cycle 1, page_status=2, zero RAM writes.
- Event coincident with success (state=2 at 0x1FFF, bit 0) → included; RAM[0x1FFF] bit 0 flipped; page_status=1.
- Abort/reset: 4 fixes pending; page_start asserted during the 2nd FIX_WAIT → exactly 1 write done, no done pulse, fix_cnt=0. Repeat with rst → all outputs 0 next cycle.

Source files
------------

// File: rtl/read_ecc_correct_if.sv
// Page buffer RAM port: the corrector drives it (master), the RAM answers (slave).
interface read_ecc_correct_if #(parameter int PAGE_AW = 13);
   logic               pram_en;
   logic               pram_we;
   logic [PAGE_AW-1:0] pram_addr;
   logic [7:0]         pram_din;
   logic [7:0]         pram_dout;

   modport master (output pram_en, pram_we, pram_addr, pram_din, input pram_dout);
   modport slave  (input pram_en, pram_we, pram_addr, pram_din, output pram_dout);
endinterface

// File: rtl/read_ecc_correct.sv
// Collects per-chunk ECC verdicts during compare, then flips the flagged bits in the
// page buffer by read-modify-write and reports a page-level status.
module read_ecc_correct #(
   parameter int MAX_FIX = 64,
   parameter int PAGE_AW = 13
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       page_start,
   input  logic [1:0]                 ecc_state_in,
   input  logic [15:0]                change_addr_in,
   input  logic                       ecc_success_in,
   read_ecc_correct_if.master         pram,
   output logic                       busy,
   output logic                       done,
   output logic [1:0]                 page_status,
   output logic [6:0]                 fix_cnt
);
   localparam int IW = $clog2(MAX_FIX);

   typedef enum logic [2:0] {IDLE, FIX_RD, FIX_WAIT, FIX_WR, DONE} state_t;
   typedef struct packed {
      logic [5:0] chunk;
      logic [6:0] byte_idx;
      logic [2:0] bit_idx;
   } fix_t;

   state_t     state, state_n;
   fix_t       fix_list [MAX_FIX];
   fix_t       cur;
   logic       uncor, ovf, uncor_n, ovf_n;
   logic       app, full, set_status;
   logic [6:0] idx, cnt_n;
   logic [7:0] rd_byte;
   logic [1:0] status_n;

   // Verdicts only count while collecting; page_start discards a same-cycle event.
   assign app     = (state == IDLE) && !page_start && (ecc_state_in == 2'd2);
   assign full    = (fix_cnt == 7'(MAX_FIX));
   assign cnt_n   = fix_cnt + 7'(app && !full);
   assign uncor_n = uncor | ((state == IDLE) && !page_start && (ecc_state_in == 2'd3));
   assign ovf_n   = ovf | (app && full);
   assign cur     = fix_list[idx[IW-1:0]];

   always_comb begin
      state_n    = state;
      set_status = 1'b0;
      status_n   = 2'd0;
      case (state)
         IDLE: if (ecc_success_in) begin
            if (uncor_n || ovf_n) begin
               state_n = DONE; set_status = 1'b1; status_n = 2'd2;
            end else if (cnt_n == 7'd0) begin
               state_n = DONE; set_status = 1'b1; status_n = 2'd0;
            end else begin
               state_n = FIX_RD;
            end
         end
         FIX_RD:   state_n = FIX_WAIT;
         FIX_WAIT: state_n = FIX_WR;
         FIX_WR: if (idx == fix_cnt - 7'd1) begin
            state_n = DONE; set_status = 1'b1; status_n = 2'd1;
         end else begin
            state_n = FIX_RD;
         end
         DONE:     state_n = IDLE;
         default:  state_n = IDLE;
      endcase
      // page_start wins everywhere: clears a finished page or aborts a fix in flight
      if (page_start) begin
         state_n    = IDLE;
         set_status = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         fix_cnt     <= 7'd0;
         uncor       <= 1'b0;
         ovf         <= 1'b0;
         idx         <= 7'd0;
         rd_byte     <= 8'd0;
         page_status <= 2'd0;
      end else begin
         state <= state_n;
         if (page_start) begin
            fix_cnt     <= 7'd0;
            uncor       <= 1'b0;
            ovf         <= 1'b0;
            page_status <= 2'd0;
         end else begin
            if (state == IDLE) begin
               fix_cnt <= cnt_n;
               uncor   <= uncor_n;
               ovf     <= ovf_n;
               idx     <= 7'd0;
            end
            if (state == FIX_WAIT) rd_byte <= pram.pram_dout;
            if (state == FIX_WR)   idx     <= idx + 7'd1;
            if (set_status)        page_status <= status_n;
         end
      end
   end

   // List storage needs no reset: fix_cnt alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && app && !full) fix_list[fix_cnt[IW-1:0]] <= fix_t'(change_addr_in);
   end

   always_comb begin
      pram.pram_en   = 1'b0;
      pram.pram_we   = 1'b0;
      pram.pram_addr = '0;
      pram.pram_din  = 8'd0;
      if (state == FIX_RD || state == FIX_WR) begin
         pram.pram_en   = 1'b1;
         pram.pram_addr = PAGE_AW'({cur.chunk, cur.byte_idx});
      end
      if (state == FIX_WR) begin
         pram.pram_we  = 1'b1;
         pram.pram_din = rd_byte ^ (8'h01 << cur.bit_idx);
      end
   end

   assign busy = (state == FIX_RD) || (state == FIX_WAIT) || (state == FIX_WR);
   assign done = (state == DONE);
endmodule
